// File: rtl/async_handshake_tx_if.sv
// Handshake bundle for async_handshake_tx: upstream valid/ready word input plus the
// 4-phase req/ack bus to the external peer.
interface async_handshake_tx_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_req;
  logic              tx_ack_a;
  logic              busy;
  logic              done;
  logic              timeout_err;

  // master is the transmitter that drives tx_req; slave is the upstream source plus the peer
  modport master (
    input  in_valid, in_data, tx_ack_a,
    output in_ready, tx_data, tx_req, busy, done, timeout_err
  );

  modport slave (
    output in_valid, in_data, tx_ack_a,
    input  in_ready, tx_data, tx_req, busy, done, timeout_err
  );
endinterface

// File: rtl/async_handshake_tx.sv
// Transmitter end of a 4-phase req/ack handshake: it latches one word, raises req after a
// setup delay, and follows the synchronized ack through both phases, aborting on a stall.
module async_handshake_tx #(
  parameter int DATA_W         = 16,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  async_handshake_tx_if.master bus
);

  localparam int SU_W = 8;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [SU_W-1:0] SETUP_LAST = SU_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, ABORT} state_t;

  state_t            state, state_nx;
  logic              ack_meta, ack_s;
  logic [SU_W-1:0]   setup_cnt, setup_cnt_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              req_q, req_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;
  logic              terr_q, terr_nx;
  logic              in_ready;
  logic              to_hit;

  // The raw ack is asynchronous; only ack_s may steer the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= bus.tx_ack_a;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      setup_cnt <= '0;
      to_cnt    <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      setup_cnt <= setup_cnt_nx;
      to_cnt    <= to_cnt_nx;
      data_q    <= data_nx;
      req_q     <= req_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      terr_q    <= terr_nx;
    end
  end

  assign in_ready = (state == IDLE) && !ack_s;
  assign to_hit   = (to_cnt == TO_LAST);

  always_comb begin
    state_nx     = state;
    setup_cnt_nx = setup_cnt;
    to_cnt_nx    = to_cnt;
    data_nx      = data_q;
    req_nx       = req_q;
    busy_nx      = busy_q;
    done_nx      = 1'b0;
    terr_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          data_nx      = bus.in_data;
          busy_nx      = 1'b1;
          setup_cnt_nx = '0;
          state_nx     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          req_nx    = 1'b1;
          to_cnt_nx = '0;
          state_nx  = REQ_HI;
        end else begin
          setup_cnt_nx = setup_cnt + SU_W'(1);
        end
      end
      // Ack is tested before the timeout so a same-edge race resolves in favour of the peer
      REQ_HI: begin
        if (ack_s) begin
          req_nx    = 1'b0;
          to_cnt_nx = '0;
          state_nx  = REQ_LO;
        end else if (to_hit) begin
          req_nx   = 1'b0;
          terr_nx  = 1'b1;
          state_nx = ABORT;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else if (to_hit) begin
          terr_nx  = 1'b1;
          state_nx = ABORT;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      ABORT: begin
        if (!ack_s) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.tx_data     = data_q;
  assign bus.tx_req      = req_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_async_handshake_tx.sv
// Self-checking bench for async_handshake_tx: directed cycle checks plus a scoreboard that
// matches every done/timeout_err pulse against the word and outcome expected at acceptance.
module tb_async_handshake_tx;

  localparam int DATA_W = 16;
  localparam int SETUP  = 2;
  localparam int TMO    = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              is_timeout;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   done_seen = 0;
  int   d0;
  int   hi_len;
  int   lo_len;
  sb_t  sb_q[$];
  sb_t  mon_e;

  async_handshake_tx_if #(.DATA_W(DATA_W)) hs ();

  async_handshake_tx #(
    .DATA_W(DATA_W),
    .SETUP_CYCLES(SETUP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(hs)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] data, input logic is_timeout);
    sb_t e;
    e.data       = data;
    e.is_timeout = is_timeout;
    sb_q.push_back(e);
  endtask

  // Pulses are sampled on the falling edge, half a cycle away from the register updates
  always @(negedge clk) begin
    if (hs.done || hs.timeout_err) begin
      if (hs.done) done_seen++;
      checkOutput("pulse_excl", 32'(hs.done && hs.timeout_err), 0);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_pulse", 32'({hs.done, hs.timeout_err}), 0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("sb_data", 32'(hs.tx_data), 32'(mon_e.data));
        checkOutput("sb_kind", 32'(hs.timeout_err), 32'(mon_e.is_timeout));
      end
    end
  end

  // One clean word; in_valid/in_data must already be presented with in_ready high
  task automatic applyStimulus(input logic [DATA_W-1:0] data, input bit hold,
                               input logic [DATA_W-1:0] next_data);
    checkOutput("rdy_before_accept", 32'(hs.in_ready), 1);
    tick();
    push_exp(data, 1'b0);
    if (hold) hs.in_data = next_data;
    else begin
      hs.in_valid = 1'b0;
      hs.in_data  = ~data;
    end
    checkOutput("data_accept", 32'(hs.tx_data), 32'(data));
    checkOutput("busy_accept", 32'(hs.busy), 1);
    checkOutput("req_accept", 32'(hs.tx_req), 0);
    for (int k = 1; k < SETUP; k++) begin
      tick();
      checkOutput("req_setup", 32'(hs.tx_req), 0);
    end
    tick();
    checkOutput("req_rise", 32'(hs.tx_req), 1);
    repeat (3) begin
      tick();
      checkOutput("rdy_busy_hi", 32'(hs.in_ready), 0);
      checkOutput("req_wait_ack", 32'(hs.tx_req), 1);
    end
    hs.tx_ack_a = 1'b1;
    repeat (2) begin
      tick();
      checkOutput("req_hold", 32'(hs.tx_req), 1);
    end
    tick();
    checkOutput("req_fall", 32'(hs.tx_req), 0);
    checkOutput("busy_lo", 32'(hs.busy), 1);
    checkOutput("data_hold", 32'(hs.tx_data), 32'(data));
    repeat (3) begin
      tick();
      checkOutput("rdy_busy_lo", 32'(hs.in_ready), 0);
      checkOutput("done_wait", 32'(hs.done), 0);
    end
    hs.tx_ack_a = 1'b0;
    repeat (2) begin
      tick();
      checkOutput("done_early", 32'(hs.done), 0);
      checkOutput("busy_release", 32'(hs.busy), 1);
    end
    tick();
    checkOutput("done_pulse", 32'(hs.done), 1);
    checkOutput("busy_done", 32'(hs.busy), 0);
    checkOutput("data_done", 32'(hs.tx_data), 32'(data));
  endtask

  task automatic accept_to_req(input logic [DATA_W-1:0] data);
    hs.in_valid = 1'b1;
    hs.in_data  = data;
    tick();
    hs.in_valid = 1'b0;
    for (int k = 1; k < SETUP; k++) tick();
    tick();
    checkOutput("req_rise_dir", 32'(hs.tx_req), 1);
  endtask

  initial begin
    hs.in_valid = 1'b0;
    hs.in_data  = '0;
    hs.tx_ack_a = 1'b0;
    rst_n       = 1'b0;
    repeat (3) tick();
    checkOutput("rst_req", 32'(hs.tx_req), 0);
    checkOutput("rst_data", 32'(hs.tx_data), 0);
    checkOutput("rst_busy", 32'(hs.busy), 0);
    checkOutput("rst_done", 32'(hs.done), 0);
    checkOutput("rst_terr", 32'(hs.timeout_err), 0);
    checkOutput("rst_ready", 32'(hs.in_ready), 1);
    rst_n = 1'b1;
    tick();

    // Clean transfer
    hs.in_valid = 1'b1;
    hs.in_data  = 16'hA5C3;
    applyStimulus(16'hA5C3, 1'b0, '0);
    tick();

    // Back-to-back with in_valid held high
    d0 = done_seen;
    hs.in_valid = 1'b1;
    hs.in_data  = 16'h0001;
    applyStimulus(16'h0001, 1'b1, 16'h0002);
    applyStimulus(16'h0002, 1'b0, '0);
    tick();
    checkOutput("b2b_done_count", 32'(done_seen - d0), 2);

    // Timeout while waiting for ack to rise
    push_exp(16'h1234, 1'b1);
    accept_to_req(16'h1234);
    hi_len = 1;
    for (int i = 0; i < 4 * TMO && hs.tx_req; i++) begin
      tick();
      if (hs.tx_req) hi_len++;
    end
    checkOutput("req_hi_len", 32'(hi_len), TMO);
    checkOutput("terr_hi", 32'(hs.timeout_err), 1);
    checkOutput("abort_busy", 32'(hs.busy), 1);
    checkOutput("abort_ready", 32'(hs.in_ready), 0);
    tick();
    checkOutput("terr_one_cycle", 32'(hs.timeout_err), 0);
    checkOutput("idle_busy", 32'(hs.busy), 0);
    checkOutput("idle_ready", 32'(hs.in_ready), 1);
    tick();

    // Timeout while waiting for ack to fall, with ack stuck high
    push_exp(16'h5A5A, 1'b1);
    accept_to_req(16'h5A5A);
    repeat (3) tick();
    hs.tx_ack_a = 1'b1;
    repeat (3) tick();
    checkOutput("req_fall_lo", 32'(hs.tx_req), 0);
    lo_len = 0;
    for (int i = 0; i < 4 * TMO && !hs.timeout_err; i++) begin
      tick();
      lo_len++;
    end
    checkOutput("req_lo_len", 32'(lo_len), TMO);
    repeat (5) begin
      tick();
      checkOutput("abort_stuck_busy", 32'(hs.busy), 1);
      checkOutput("abort_stuck_ready", 32'(hs.in_ready), 0);
    end
    hs.tx_ack_a = 1'b0;
    repeat (2) begin
      tick();
      checkOutput("abort_hold", 32'(hs.busy), 1);
    end
    tick();
    checkOutput("abort_exit_busy", 32'(hs.busy), 0);
    checkOutput("abort_exit_ready", 32'(hs.in_ready), 1);
    tick();

    // ack_s arrives on the same edge the timeout counter reaches its last value
    push_exp(16'hC0DE, 1'b0);
    accept_to_req(16'hC0DE);
    repeat (TMO - 3) tick();
    hs.tx_ack_a = 1'b1;
    repeat (2) tick();
    checkOutput("race_req_before", 32'(hs.tx_req), 1);
    tick();
    checkOutput("race_req", 32'(hs.tx_req), 0);
    checkOutput("race_terr", 32'(hs.timeout_err), 0);
    checkOutput("race_busy", 32'(hs.busy), 1);
    hs.tx_ack_a = 1'b0;
    repeat (2) tick();
    tick();
    checkOutput("race_done", 32'(hs.done), 1);
    tick();

    // Spurious ack in IDLE only blocks acceptance
    hs.tx_ack_a = 1'b1;
    repeat (3) tick();
    checkOutput("spur_ready", 32'(hs.in_ready), 0);
    hs.in_valid = 1'b1;
    hs.in_data  = 16'h7777;
    repeat (3) tick();
    checkOutput("spur_busy", 32'(hs.busy), 0);
    checkOutput("spur_req", 32'(hs.tx_req), 0);
    hs.in_valid = 1'b0;
    hs.tx_ack_a = 1'b0;
    repeat (3) tick();
    checkOutput("spur_clear_ready", 32'(hs.in_ready), 1);

    // Reset pulse while in REQ_HI, then a normal word
    accept_to_req(16'hBEEF);
    repeat (2) tick();
    checkOutput("pre_reset_req", 32'(hs.tx_req), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_req", 32'(hs.tx_req), 0);
    checkOutput("midrst_data", 32'(hs.tx_data), 0);
    checkOutput("midrst_busy", 32'(hs.busy), 0);
    checkOutput("midrst_done", 32'(hs.done), 0);
    checkOutput("midrst_terr", 32'(hs.timeout_err), 0);
    rst_n = 1'b1;
    tick();
    hs.in_valid = 1'b1;
    hs.in_data  = 16'h00FF;
    applyStimulus(16'h00FF, 1'b0, '0);

    repeat (3) tick();
    checkOutput("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
